// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two packet requesters, the 2:1 round-robin arbiter
// and the downstream sink.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data_in_0;
    logic [WIDTH-1:0] Data_in_1;
    logic             valid_0;
    logic             valid_1;
    logic             last_0;
    logic             last_1;
    logic             ready_0;
    logic             ready_1;
    logic             out_ready;
    logic [WIDTH-1:0] Data_out;
    logic             out_valid;
    logic             out_last;
    logic             sel;
    logic             grant_0;
    logic             grant_1;
    logic             forced_release;

    modport master (
        output Data_in_0, Data_in_1, valid_0, valid_1, last_0, last_1, out_ready,
        input  ready_0, ready_1, Data_out, out_valid, out_last, sel,
               grant_0, grant_1, forced_release
    );

    modport slave (
        input  Data_in_0, Data_in_1, valid_0, valid_1, last_0, last_1, out_ready,
        output ready_0, ready_1, Data_out, out_valid, out_last, sel,
               grant_0, grant_1, forced_release
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-input packet arbiter: round-robin grant per packet, 2:1 data mux, and a
// beat limit that forces release of a grant whose packet never ends.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                reset,
    mux2_rr_arbiter_if.slave    bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             last_gnt_r;      // 1: requester 1 was granted most recently
    logic             last_gnt_nxt_s;
    logic [7:0]       beat_cnt_r;
    logic             sel_r;
    logic             sel_nxt_s;
    logic             grant_0_r;
    logic             grant_1_r;
    logic             forced_r;
    logic             forced_nxt_s;
    logic             out_valid_s;
    logic             out_last_s;
    logic             xfer_s;
    logic             at_limit_s;
    logic [WIDTH-1:0] data_sel_s;

    // Selected valid/last follow the granted requester; nothing is offered in IDLE.
    always_comb begin
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        case (state_r)
            GNT0: begin
                out_valid_s = bus.valid_0;
                out_last_s  = bus.last_0;
            end
            GNT1: begin
                out_valid_s = bus.valid_1;
                out_last_s  = bus.last_1;
            end
            default: begin
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
    end

    assign xfer_s     = out_valid_s & bus.out_ready;
    assign at_limit_s = (beat_cnt_r == LAST_CNT);
    assign data_sel_s = sel_r ? bus.Data_in_1 : bus.Data_in_0;

    // Grant FSM; a timeout release only counts as forced when last is not also present.
    always_comb begin
        state_nxt_s    = state_r;
        last_gnt_nxt_s = last_gnt_r;
        forced_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.valid_0 && bus.valid_1) begin
                    state_nxt_s = last_gnt_r ? GNT0 : GNT1;
                end else if (bus.valid_0) begin
                    state_nxt_s = GNT0;
                end else if (bus.valid_1) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (xfer_s && (bus.last_0 || at_limit_s)) begin
                    state_nxt_s    = IDLE;
                    last_gnt_nxt_s = 1'b0;
                    forced_nxt_s   = ~bus.last_0;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (xfer_s && (bus.last_1 || at_limit_s)) begin
                    state_nxt_s    = IDLE;
                    last_gnt_nxt_s = 1'b1;
                    forced_nxt_s   = ~bus.last_1;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Mux select tracks the next grant and holds its value through IDLE.
    always_comb begin
        case (state_nxt_s)
            GNT0:    sel_nxt_s = 1'b0;
            GNT1:    sel_nxt_s = 1'b1;
            default: sel_nxt_s = sel_r;
        endcase
    end

    // State, priority record and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b1;
            sel_r      <= 1'b0;
            grant_0_r  <= 1'b0;
            grant_1_r  <= 1'b0;
            forced_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            sel_r      <= sel_nxt_s;
            grant_0_r  <= (state_nxt_s == GNT0);
            grant_1_r  <= (state_nxt_s == GNT1);
            forced_r   <= forced_nxt_s;
        end
    end

    // Beat counter: cleared while idle so every grant starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= 8'd0;
        end else if (state_r == IDLE) begin
            beat_cnt_r <= 8'd0;
        end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end
    end

    assign bus.Data_out       = data_sel_s;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_last       = out_last_s;
    assign bus.sel            = sel_r;
    assign bus.grant_0        = grant_0_r;
    assign bus.grant_1        = grant_1_r;
    assign bus.ready_0        = bus.out_ready & grant_0_r;
    assign bus.ready_1        = bus.out_ready & grant_1_r;
    assign bus.forced_release = forced_r;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a per-cycle vector table followed by
// hand-written timeout, last-at-limit and mid-packet reset sequences.
module tb_mux2_rr_arbiter;
    logic clk;
    logic reset;
    int   total_cnt;
    int   pass_cnt;

    mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BEATS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in:  {valid_0, valid_1, last_0, last_1, out_ready}
    // exp: {grant_0, grant_1, sel, out_valid, out_last, ready_0, ready_1, forced_release}
    typedef struct {
        logic [4:0] in;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] exp;
        logic [7:0] dout;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] in, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] exp, input logic [7:0] dout);
        vec_t v;
        v.in = in; v.d0 = d0; v.d1 = d1; v.exp = exp; v.dout = dout;
        vq.push_back(v);
    endtask

    function automatic logic [7:0] flags();
        return {bus.grant_0, bus.grant_1, bus.sel, bus.out_valid, bus.out_last,
                bus.ready_0, bus.ready_1, bus.forced_release};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic drive(input logic [4:0] in, input logic [7:0] d0, input logic [7:0] d1);
        {bus.valid_0, bus.valid_1, bus.last_0, bus.last_1, bus.out_ready} = in;
        bus.Data_in_0 = d0;
        bus.Data_in_1 = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        reset = 1'b1;
        drive(5'b00000, 8'h00, 8'h00);

        // both requesters, 3-beat packets, order 0,1,0,1 with an idle cycle between
        add(5'b11001, 8'h11, 8'h22, 8'b00000000, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b10010100, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b10010100, 8'h11);
        add(5'b11101, 8'h11, 8'h22, 8'b10011100, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b00000000, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b01110010, 8'h22);
        add(5'b11001, 8'h11, 8'h22, 8'b01110010, 8'h22);
        add(5'b11011, 8'h11, 8'h22, 8'b01111010, 8'h22);
        add(5'b11001, 8'h11, 8'h22, 8'b00100000, 8'h22);
        add(5'b11001, 8'h11, 8'h22, 8'b10010100, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b10010100, 8'h11);
        add(5'b11101, 8'h11, 8'h22, 8'b10011100, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b00000000, 8'h11);
        add(5'b11001, 8'h11, 8'h22, 8'b01110010, 8'h22);
        add(5'b11001, 8'h11, 8'h22, 8'b01110010, 8'h22);
        add(5'b11011, 8'h11, 8'h22, 8'b01111010, 8'h22);
        add(5'b00001, 8'h11, 8'h22, 8'b00100000, 8'h22);
        // only requester 1, 2-beat packet of 8'hA5
        add(5'b01001, 8'h3C, 8'hA5, 8'b00100000, 8'hA5);
        add(5'b01001, 8'h3C, 8'hA5, 8'b01110010, 8'hA5);
        add(5'b01011, 8'h3C, 8'hA5, 8'b01111010, 8'hA5);
        add(5'b00001, 8'h3C, 8'hA5, 8'b00100000, 8'hA5);
        // requester 0 with out_ready toggling and valid_0 dropping for two cycles
        add(5'b10001, 8'h3C, 8'hA5, 8'b00100000, 8'hA5);
        add(5'b10001, 8'h3C, 8'hA5, 8'b10010100, 8'h3C);
        add(5'b10000, 8'h3C, 8'hA5, 8'b10010000, 8'h3C);
        add(5'b10001, 8'h3C, 8'hA5, 8'b10010100, 8'h3C);
        add(5'b10000, 8'h3C, 8'hA5, 8'b10010000, 8'h3C);
        add(5'b00001, 8'h3C, 8'hA5, 8'b10000100, 8'h3C);
        add(5'b00001, 8'h3C, 8'hA5, 8'b10000100, 8'h3C);
        add(5'b10101, 8'h3C, 8'hA5, 8'b10011100, 8'h3C);
        add(5'b00001, 8'h3C, 8'hA5, 8'b00000000, 8'h3C);

        tick();
        tick();
        check("reset_flags", {24'd0, flags()}, 32'h0000_0000);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in, vq[i].d0, vq[i].d1);
            #1;
            check($sformatf("vec%0d_flags", i), {24'd0, flags()}, {24'd0, vq[i].exp});
            check($sformatf("vec%0d_dout", i), {24'd0, bus.Data_out}, {24'd0, vq[i].dout});
            tick();
        end

        // timeout: requester 0 never sends last, requester 1 waits
        drive(5'b10001, 8'h01, 8'h02);
        tick();
        for (int k = 1; k <= 16; k++) begin
            drive(5'b11001, 8'h01, 8'h02);
            #1;
            check($sformatf("to_beat%0d_grant0", k), {31'd0, bus.grant_0}, 32'd1);
            check($sformatf("to_beat%0d_forced", k), {31'd0, bus.forced_release}, 32'd0);
            tick();
        end
        check("to_release_forced", {31'd0, bus.forced_release}, 32'd1);
        check("to_release_idle", {30'd0, bus.grant_0, bus.grant_1}, 32'd0);
        tick();
        check("to_next_grant1", {30'd0, bus.grant_0, bus.grant_1}, 32'd1);
        check("to_next_forced", {31'd0, bus.forced_release}, 32'd0);

        // last_1 arrives exactly on the transfer at the beat limit
        for (int k = 1; k <= 15; k++) begin
            drive(5'b01001, 8'h01, 8'h02);
            #1;
            check($sformatf("lim_beat%0d_grant1", k), {31'd0, bus.grant_1}, 32'd1);
            tick();
        end
        drive(5'b01011, 8'h01, 8'h02);
        #1;
        check("lim_last_beat", {24'd0, flags()}, {24'd0, 8'b01111010});
        tick();
        check("lim_release", {24'd0, flags()}, {24'd0, 8'b00100000});

        // mid-packet reset after requester 0 was most recently granted
        drive(5'b10101, 8'h01, 8'h02);
        tick();
        tick();
        drive(5'b01001, 8'h01, 8'h02);
        tick();
        tick();
        tick();
        check("rst_pre_grant1", {24'd0, flags()}, {24'd0, 8'b01110010});
        reset = 1'b1;
        #1;
        check("rst_async_flags", {24'd0, flags()}, 32'd0);
        tick();
        check("rst_held_flags", {24'd0, flags()}, 32'd0);
        reset = 1'b0;
        drive(5'b11001, 8'h01, 8'h02);
        #1;
        check("rst_idle_flags", {24'd0, flags()}, 32'd0);
        tick();
        check("rst_first_grant0", {24'd0, flags()}, {24'd0, 8'b10010100});
        check("rst_first_dout", {24'd0, bus.Data_out}, 32'h0000_0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width of each input and of the output.
REQ-002 The module SHALL have parameter MAX_BEATS, default 16, giving the maximum beats per grant before forced release (legal range 2..256).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Data_in_0  input  WIDTH  requester 0 data.
REQ-006 Data_in_1  input  WIDTH  requester 1 data.
REQ-007 valid_0 / valid_1  input  1 each  beat present on the matching Data_in; also serves as that requester's request.
REQ-008 last_0 / last_1  input  1 each  final beat of that requester's packet.
REQ-009 ready_0 / ready_1  output  1 each  beat on the matching input accepted this cycle.
REQ-010 out_ready  input  1  downstream accepts a beat.
REQ-011 Data_out  output  WIDTH  selected data.
REQ-012 out_valid / out_last  output  1 each  selected valid and last.
REQ-013 sel  output  1  current mux select (0 = input 0, 1 = input 1).
REQ-014 grant_0 / grant_1  output  1 each  one-hot-or-zero grant indication.
REQ-015 forced_release  output  1  registered one-cycle pulse when a grant ends by timeout.

Function
REQ-016 The FSM SHALL have states IDLE, GNT0 and GNT1.
REQ-017 In IDLE, with exactly one valid_x high, the FSM SHALL enter GNTx on the next edge.
REQ-018 In IDLE, with both valid_0 and valid_1 high, the FSM SHALL enter the GNT state of the requester not granted most recently; after reset, requester 0 wins.
REQ-019 In IDLE, with neither valid high, the FSM SHALL remain in IDLE.
REQ-020 The grant latency from a request in IDLE SHALL be one cycle; no beat is transferred in IDLE.
REQ-021 sel SHALL be a registered output: 1 in GNT1, 0 in GNT0, and its previous value held in IDLE.
REQ-022 grant_x SHALL be 1 exactly while in GNTx.
REQ-023 Data_out SHALL equal Data_in_1 when sel=1 and Data_in_0 otherwise, combinationally, in every state.
REQ-024 In GNTx, out_valid SHALL equal valid_x and out_last SHALL equal last_x; in IDLE both SHALL be 0.
REQ-025 ready_x SHALL equal out_ready AND grant_x; the non-granted ready SHALL be 0.
REQ-026 A beat SHALL transfer on any edge where out_valid and out_ready are both 1.
REQ-027 An 8-bit beat counter SHALL clear on grant entry and increment by one on each transferred beat.
REQ-028 On a transfer with last_x=1, the FSM SHALL go to IDLE and record x as most recently granted.
REQ-029 On a transfer with last_x=0 and the counter equal to MAX_BEATS-1, the FSM SHALL go to IDLE, record x, and assert forced_release for the following cycle only.
REQ-030 If last_x=1 and the counter equals MAX_BEATS-1 on the same transfer, the release SHALL be normal, with no forced_release.
REQ-031 Dropping valid_x while in GNTx SHALL NOT release the grant: the grant holds until last or timeout.
REQ-032 A release SHALL always pass through one IDLE cycle, so the minimum gap between grants is one cycle.

Reset
REQ-033 While reset=1, state SHALL be IDLE, with sel=0, grant_0=grant_1=0, out_valid=0, out_last=0, ready_0=ready_1=0, forced_release=0, beat counter=0, and the most-recent record set so that requester 0 wins first.
REQ-034 An assertion of reset mid-packet SHALL abort the grant immediately (asynchronously), and the next grant SHALL follow REQ-018 from the reset priority.

Verification
REQ-035 Both valid from reset, each sending 3-beat packets, out_ready=1 -> grant order 0,1,0,1; each packet 3 beats; one IDLE cycle between grants.
REQ-036 Only valid_1 high, 2-beat packet, Data_in_1=8'hA5 -> sel=1 one cycle after request; Data_out=8'hA5; ready_1=1 and ready_0=0 throughout.
REQ-037 Requester 0 streams with last_0=0, MAX_BEATS=16 -> release after 16th transfer; forced_release high one cycle; requester 1 (pending) granted next.
REQ-038 In GNT0, out_ready toggling 1,0,1,0 -> ready_0 mirrors out_ready; counter advances only on transfer cycles; grant held while valid_0 drops for 2 cycles.
REQ-039 reset pulsed after beat 2 of a packet from 1 -> outputs return immediately to REQ-033 values; with both requesting afterwards, requester 0 is granted first.
REQ-040 last_1=1 on the transfer where the counter equals 15 -> normal release with forced_release=0.
